// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: ALU mode codes,
// flag bit positions, sequencer state encoding and the op-to-mode mapping.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADC  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SBB  = 4'b0011;
  localparam logic [3:0] ALU_SHL  = 4'b0100;
  localparam logic [3:0] ALU_SHR  = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_OR   = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_NOT  = 4'b1001;
  localparam logic [3:0] ALU_NAND = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1011;

  localparam int FLG_C  = 0;
  localparam int FLG_B  = 1;
  localparam int FLG_Z  = 2;
  localparam int FLG_LT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic is_add_op(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_ADC);
  endfunction

  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_SBB);
  endfunction

  // Every nibble pass of an add/sub needs the chained variant of the ALU mode.
  function automatic logic [3:0] alu_mode_map(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_ADC: return ALU_ADC;
      ALU_SUB, ALU_SBB: return ALU_SBB;
      ALU_SHL, ALU_SHR, ALU_AND, ALU_OR,
      ALU_XOR, ALU_NOT, ALU_NAND, ALU_NOR: return op;
      default: return op;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_flag_acc.sv
// Per-nibble result patching for shifts, carry/borrow chain register and
// accumulation of the wide C/B/Z/LT flags across nibble passes.
module alu_seq_flag_acc
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       start_chain_i,
  input  logic       exec_i,
  input  logic       last_i,
  input  logic [3:0] op_i,
  input  logic [3:0] a_nib_i,
  input  logic [3:0] b_nib_i,
  input  logic       a_prev_b3_i,
  input  logic       a_next_b0_i,
  input  logic       a_msb_i,
  input  logic       a_lsb_i,
  input  logic [3:0] alu_c_i,
  input  logic [3:0] alu_flags_i,
  output logic [3:0] res_nib_o,
  output logic       chain_o,
  output logic [3:0] flags_o
);

  logic       chain_q, chain_d;
  logic       lt_q, lt_d;
  logic       z_q, z_d;
  logic [3:0] flags_q, flags_d;
  logic       lt_nib, z_nib;
  logic       unused_alu_z;

  // The ALU's own zero flag only covers one nibble; Z is rebuilt locally.
  assign unused_alu_z = alu_flags_i[FLG_Z];

  always_comb begin
    res_nib_o = alu_c_i;
    if (op_i == ALU_SHL) res_nib_o[0] = a_prev_b3_i;
    if (op_i == ALU_SHR) res_nib_o[3] = a_next_b0_i;

    lt_nib  = alu_flags_i[FLG_LT] | ((a_nib_i == b_nib_i) & lt_q);
    z_nib   = z_q & (res_nib_o == 4'd0);
    chain_d = chain_q;
    lt_d    = lt_q;
    z_d     = z_q;
    flags_d = flags_q;

    if (start_i) begin
      chain_d = start_chain_i;
      lt_d    = 1'b0;
      z_d     = 1'b1;
    end else if (exec_i) begin
      chain_d = is_sub_op(op_i) ? alu_flags_i[FLG_B] : alu_flags_i[FLG_C];
      lt_d    = lt_nib;
      z_d     = z_nib;
      if (last_i) begin
        if (is_add_op(op_i))       flags_d[FLG_C] = alu_flags_i[FLG_C];
        else if (op_i == ALU_SHL)  flags_d[FLG_C] = a_msb_i;
        else if (op_i == ALU_SHR)  flags_d[FLG_C] = a_lsb_i;
        else                       flags_d[FLG_C] = 1'b0;
        flags_d[FLG_B]  = is_sub_op(op_i) ? alu_flags_i[FLG_B] : 1'b0;
        flags_d[FLG_Z]  = z_nib;
        flags_d[FLG_LT] = lt_nib;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= 1'b0;
      lt_q    <= 1'b0;
      z_q     <= 1'b1;
      flags_q <= 4'd0;
    end else begin
      chain_q <= chain_d;
      lt_q    <= lt_d;
      z_q     <= z_d;
      flags_q <= flags_d;
    end
  end

  assign chain_o = chain_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/alu_seq.sv
// Nibble-serial wide-operation sequencer in front of a shared 4-bit ALU.
// Define ALU_SEQ_B2B_EN to allow back-to-back response/request handshakes in DONE.
module alu_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic                 req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_result,
  output logic [3:0]           rsp_flags,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_mode,
  output logic                 alu_carry_f,
  output logic                 alu_borrow_f,
  input  logic [3:0]           alu_c,
  input  logic [3:0]           alu_flags
);

  localparam int W = 4 * NIBBLES;

  seq_state_e     state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;

  logic           exec, last, accept, start_chain, chain;
  logic [3:0]     a_nib, b_nib, res_nib;
  logic           a_prev_b3, a_next_b0;
  logic [W-1:0]   a_shl, a_shr;

  assign exec = (state_q == ST_EXEC);
  assign last = (idx_q == 2'(NIBBLES - 1));

`ifdef ALU_SEQ_B2B_EN
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && rsp_ready);
`else
  assign req_ready = (state_q == ST_IDLE);
`endif

  assign accept      = req_valid && req_ready;
  assign start_chain = req_cin && ((req_op == ALU_ADC) || (req_op == ALU_SBB));

  // Bit 4i of a_shl is a[4i-1] and bit 4i+3 of a_shr is a[4i+4], zero at the ends.
  assign a_shl = {a_q[W-2:0], 1'b0};
  assign a_shr = {1'b0, a_q[W-1:1]};

  always_comb begin
    a_nib     = 4'd0;
    b_nib     = 4'd0;
    a_prev_b3 = 1'b0;
    a_next_b0 = 1'b0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == 2'(i)) begin
        a_nib     = a_q[4*i +: 4];
        b_nib     = b_q[4*i +: 4];
        a_prev_b3 = a_shl[4*i];
        a_next_b0 = a_shr[4*i+3];
      end
    end
  end

  alu_seq_flag_acc u_flag_acc (
    .clk           (clk),
    .rst           (rst),
    .start_i       (accept),
    .start_chain_i (start_chain),
    .exec_i        (exec),
    .last_i        (last),
    .op_i          (op_q),
    .a_nib_i       (a_nib),
    .b_nib_i       (b_nib),
    .a_prev_b3_i   (a_prev_b3),
    .a_next_b0_i   (a_next_b0),
    .a_msb_i       (a_q[W-1]),
    .a_lsb_i       (a_q[0]),
    .alu_c_i       (alu_c),
    .alu_flags_i   (alu_flags),
    .res_nib_o     (res_nib),
    .chain_o       (chain),
    .flags_o       (rsp_flags)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    result_d = result_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;

    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: begin
        if (last) state_d = ST_DONE;
        else      idx_d   = idx_q + 2'd1;
      end
      ST_DONE: if (rsp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NIBBLES; i++) begin
      if (exec && (idx_q == 2'(i))) result_d[4*i +: 4] = res_nib;
    end

    if (accept) begin
      op_d  = req_op;
      a_d   = req_a;
      b_d   = req_b;
      idx_d = 2'd0;
    end

    rsp_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = result_q;
  assign alu_a        = exec ? a_nib : 4'd0;
  assign alu_b        = exec ? b_nib : 4'd0;
  assign alu_mode     = exec ? alu_mode_map(op_q) : 4'd0;
  assign alu_carry_f  = exec && is_add_op(op_q) && chain;
  assign alu_borrow_f = exec && is_sub_op(op_q) && chain;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (NIBBLES=2) with a behavioural 4-bit ALU attached.
module tb_alu_seq;

  localparam int NIBBLES = 2;
  localparam int W = 4 * NIBBLES;
`ifdef ALU_SEQ_B2B_EN
  localparam int EXP_GAP = 3;
`else
  localparam int EXP_GAP = 4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = 4'd0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_cin = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [3:0]   alu_a, alu_b, alu_mode;
  logic         alu_carry_f, alu_borrow_f;
  logic [3:0]   alu_c, alu_flags;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.NIBBLES(NIBBLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_mode     (alu_mode),
    .alu_carry_f  (alu_carry_f),
    .alu_borrow_f (alu_borrow_f),
    .alu_c        (alu_c),
    .alu_flags    (alu_flags)
  );

  // Behavioural 4-bit ALU: flags {LT, Z, B, C}.
  logic [4:0] m_sum, m_dif;
  always_comb begin
    m_sum     = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_carry_f};
    m_dif     = {1'b0, alu_a} - {1'b0, alu_b} - {4'd0, alu_borrow_f};
    alu_c     = 4'd0;
    alu_flags = 4'd0;
    case (alu_mode)
      4'h0: begin alu_c = alu_a + alu_b; alu_flags[0] = ({1'b0, alu_a} + {1'b0, alu_b}) > 5'd15; end
      4'h1: begin alu_c = m_sum[3:0]; alu_flags[0] = m_sum[4]; end
      4'h2: begin alu_c = alu_a - alu_b; alu_flags[1] = alu_a < alu_b; end
      4'h3: begin alu_c = m_dif[3:0]; alu_flags[1] = m_dif[4]; end
      4'h4: begin alu_c = {alu_a[2:0], 1'b0}; alu_flags[0] = alu_a[3]; end
      4'h5: begin alu_c = {1'b0, alu_a[3:1]}; alu_flags[0] = alu_a[0]; end
      4'h6: alu_c = alu_a & alu_b;
      4'h7: alu_c = alu_a | alu_b;
      4'h8: alu_c = alu_a ^ alu_b;
      4'h9: alu_c = ~alu_a;
      4'hA: alu_c = ~(alu_a & alu_b);
      4'hB: alu_c = ~(alu_a | alu_b);
      default: alu_c = 4'd0;
    endcase
    alu_flags[2] = (alu_c == 4'd0);
    alu_flags[3] = (alu_a < alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin,
                        input logic [7:0] exp_res, input logic [3:0] exp_flg);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 10) begin tick(); cyc++; end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    tick();
    req_valid = 1'b0;
    cyc = 1;
    check({tag, "_alu_a0"}, {28'd0, alu_a}, {28'd0, a[3:0]});
    while (!rsp_valid && cyc < 20) begin tick(); cyc++; end
    check({tag, "_lat"}, cyc, 3);
    check({tag, "_res"}, {24'd0, rsp_result}, {24'd0, exp_res});
    check({tag, "_flg"}, {28'd0, rsp_flags}, {28'd0, exp_flg});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] tp_a [3];
    logic [7:0] tp_exp [3];
    int acc_cyc [3];
    int n_acc, n_rsp, t, seen, cyc;
    logic hs;

    tp_a   = '{8'h10, 8'h20, 8'h30};
    tp_exp = '{8'h11, 8'h21, 8'h31};
    acc_cyc = '{0, 0, 0};

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_result", {24'd0, rsp_result}, 0);
    check("rst_flags", {28'd0, rsp_flags}, 0);
    check("rst_alu_side", {18'd0, alu_a, alu_b, alu_mode, alu_carry_f, alu_borrow_f}, 0);

    //      tag        op     a      b      cin   result  {LT,Z,B,C}
    run_op("add7f",   4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0000);
    run_op("addff",   4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0101);
    run_op("add_cin", 4'h0, 8'h0F, 8'h00, 1'b1, 8'h0F, 4'b0000);
    run_op("adc",     4'h1, 8'h0F, 8'h00, 1'b1, 8'h10, 4'b0000);
    run_op("sub10",   4'h2, 8'h10, 8'h01, 1'b0, 8'h0F, 4'b0000);
    run_op("sub00",   4'h2, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1010);
    run_op("sbb05",   4'h3, 8'h05, 8'h02, 1'b1, 8'h02, 4'b0000);
    run_op("sbb00",   4'h3, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b0010);
    run_op("shl58",   4'h4, 8'h58, 8'h00, 1'b0, 8'hB0, 4'b0000);
    run_op("shr81",   4'h5, 8'h81, 8'h00, 1'b0, 8'h40, 4'b0001);
    run_op("and",     4'h6, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000);
    run_op("op_c",    4'hC, 8'h12, 8'h34, 1'b0, 8'h00, 4'b1100);

    // Backpressure: response held for 5 cycles.
    req_valid = 1'b1; req_op = 4'h0; req_a = 8'h7F; req_b = 8'h01; req_cin = 1'b0;
    tick();
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin tick(); cyc++; end
    check("bp_lat", cyc, 3);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'd0, rsp_valid}, 1);
      check("bp_result", {24'd0, rsp_result}, 32'h80);
      check("bp_req_ready", {31'd0, req_ready}, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_release", {31'd0, rsp_valid}, 0);

    // Reset during the first EXEC cycle.
    req_valid = 1'b1; req_op = 4'h0; req_a = 8'h11; req_b = 8'h22;
    tick();
    req_valid = 1'b0;
    check("rx_alu_mode", {28'd0, alu_mode}, 1);
    check("rx_alu_b0", {28'd0, alu_b}, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rx_req_ready", {31'd0, req_ready}, 1);
    check("rx_alu_side", {18'd0, alu_a, alu_b, alu_mode, alu_carry_f, alu_borrow_f}, 0);
    check("rx_result", {24'd0, rsp_result}, 0);
    seen = 0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) seen++;
      tick();
    end
    rsp_ready = 1'b0;
    check("rx_no_rsp", seen, 0);

    // Throughput with request and response handshakes held open.
    n_acc = 0; n_rsp = 0; t = 0;
    req_op = 4'h0; req_b = 8'h01; req_cin = 1'b0; req_a = tp_a[0];
    req_valid = 1'b1; rsp_ready = 1'b1;
    while (n_rsp < 3 && t < 60) begin
      hs = req_valid && req_ready;
      if (rsp_valid) begin
        check("tp_result", {24'd0, rsp_result}, {24'd0, tp_exp[n_rsp]});
        n_rsp++;
      end
      if (hs) begin acc_cyc[n_acc] = t; n_acc++; end
      tick();
      t++;
      if (hs) begin
        if (n_acc < 3) req_a = tp_a[n_acc];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("tp_n_rsp", n_rsp, 3);
    check("tp_n_acc", n_acc, 3);
    check("tp_gap01", acc_cyc[1] - acc_cyc[0], EXP_GAP);
    check("tp_gap12", acc_cyc[2] - acc_cyc[1], EXP_GAP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
